// File: rtl/prescaler_pkg.sv
// rtl/prescaler_pkg.sv - shared output-mode codes and width helper for the prescaler bank
package prescaler_pkg;

  localparam logic MODE_TOGGLE = 1'b0;
  localparam logic MODE_PULSE  = 1'b1;

  function automatic int clog2(input longint unsigned value);
    int             result;
    longint unsigned span;
    result = 0;
    span   = 1;
    while (span < value) begin
      span   = span << 1;
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/prescaler_ch.sv
// rtl/prescaler_ch.sv - one channel: divides the shared base tick, drives a square wave or strobe
module prescaler_ch
  import prescaler_pkg::*;
#(
  parameter int               DIV_W   = 8,
  parameter logic [DIV_W-1:0] DIV_RST = '0
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic             tick,
  input  logic             en,
  input  logic             clr,
  input  logic             ld,
  input  logic [DIV_W-1:0] ld_div,
  input  logic             ld_mode,
  output logic             d
);

  logic [DIV_W-1:0] cnt;
  logic [DIV_W-1:0] div_q;
  logic             mode;

  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      cnt   <= '0;
      div_q <= DIV_RST;
      mode  <= MODE_TOGGLE;
      d     <= 1'b0;
    end else begin
      if (ld) begin
        div_q <= ld_div;
        mode  <= ld_mode;
      end
      // Realign, reprogram and disable all restart the channel from a clean phase.
      if (clr || ld || !en) begin
        cnt <= '0;
        d   <= 1'b0;
      end else if (tick && cnt == div_q) begin
        cnt <= '0;
        d   <= (mode == MODE_PULSE) ? 1'b1 : ~d;
      end else begin
        if (tick) cnt <= cnt + DIV_W'(1);
        if (mode == MODE_PULSE) d <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/prescaler_bank.sv
// rtl/prescaler_bank.sv - shared base divider plus NCH programmable clock-enable channels
module prescaler_bank
  import prescaler_pkg::*;
#(
  parameter int               NCH      = 8,
  parameter int               BASE_DIV = 1048576,
  parameter int               DIV_W    = 8,
  parameter logic [DIV_W-1:0] DIV_RST  = '0,
  localparam int              CH_W     = (clog2(NCH) < 1) ? 1 : clog2(NCH)
) (
  input  logic             clk_in,
  input  logic             rst_n,
  input  logic [NCH-1:0]   ch_en,
  input  logic             sync,
  input  logic             wr_en,
  input  logic [CH_W-1:0]  wr_ch,
  input  logic [DIV_W-1:0] wr_div,
  input  logic             wr_mode,
  output logic             base_tick,
  output logic [NCH-1:0]   D
);

  localparam int                BASE_W    = (clog2(BASE_DIV) < 1) ? 1 : clog2(BASE_DIV);
  localparam logic [BASE_W-1:0] BASE_LAST = BASE_W'(BASE_DIV - 1);

  logic [BASE_W-1:0] base_cnt;
  logic              base_wrap;
  logic              wr_hit;
  logic [NCH-1:0]    ld;

  assign base_wrap = (base_cnt == BASE_LAST);

  // Sync overrides a coincident wrap, so no tick escapes on a realign cycle.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      base_cnt  <= '0;
      base_tick <= 1'b0;
    end else if (sync) begin
      base_cnt  <= '0;
      base_tick <= 1'b0;
    end else begin
      base_cnt  <= base_wrap ? '0 : base_cnt + BASE_W'(1);
      base_tick <= base_wrap;
    end
  end

  assign wr_hit = wr_en && (32'(wr_ch) < NCH);

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign ld[g] = wr_hit && (wr_ch == CH_W'(g));

    prescaler_ch #(
      .DIV_W   (DIV_W),
      .DIV_RST (DIV_RST)
    ) u_ch (
      .clk_in  (clk_in),
      .rst_n   (rst_n),
      .tick    (base_tick),
      .en      (ch_en[g]),
      .clr     (sync),
      .ld      (ld[g]),
      .ld_div  (wr_div),
      .ld_mode (wr_mode),
      .d       (D[g])
    );
  end

endmodule

// File: tb/tb_prescaler_bank.sv
// tb/tb_prescaler_bank.sv - directed cycle-exact checks of the prescaler bank
module tb_prescaler_bank;

  logic       clk;
  logic       rst_n;
  logic [3:0] ch_en;
  logic       sync;
  logic       wr_en;
  logic [1:0] wr_ch;
  logic [3:0] wr_div;
  logic       wr_mode;
  logic       base_tick;
  logic [3:0] d;

  logic [2:0] ch_en2;
  logic       sync2;
  logic [1:0] wr_ch2;
  logic       base_tick2;
  logic [2:0] d2;

  int vectors;
  int miscompares;
  int cyc;

  prescaler_bank #(.NCH(4), .BASE_DIV(4), .DIV_W(4), .DIV_RST(4'd0)) dut (
    .clk_in(clk), .rst_n(rst_n), .ch_en(ch_en), .sync(sync), .wr_en(wr_en),
    .wr_ch(wr_ch), .wr_div(wr_div), .wr_mode(wr_mode), .base_tick(base_tick), .D(d)
  );

  // Three-channel bank whose writes always target the nonexistent index 3.
  prescaler_bank #(.NCH(3), .BASE_DIV(4), .DIV_W(4), .DIV_RST(4'd0)) dut_oor (
    .clk_in(clk), .rst_n(rst_n), .ch_en(ch_en2), .sync(sync2), .wr_en(wr_en),
    .wr_ch(wr_ch2), .wr_div(wr_div), .wr_mode(wr_mode), .base_tick(base_tick2), .D(d2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic adv(input int target);
    while (cyc < target) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic write(input logic [1:0] ch, input logic [3:0] dv, input logic md);
    wr_en   = 1'b1;
    wr_ch   = ch;
    wr_div  = dv;
    wr_mode = md;
  endtask

  initial begin
    vectors = 0; miscompares = 0; cyc = 0;
    rst_n = 1'b0; ch_en = 4'h0; sync = 1'b0; wr_en = 1'b0;
    wr_ch = 2'd0; wr_div = 4'd0; wr_mode = 1'b0;
    ch_en2 = 3'b111; sync2 = 1'b0; wr_ch2 = 2'd3;

    repeat (3) @(negedge clk);
    chk("rst_d", 32'(d), 32'h0);
    chk("rst_tick", 32'(base_tick), 32'h0);
    chk("rst_d2", 32'(d2), 32'h0);

    // Release; ch1 programmed div=2 TOGGLE on the first edge.
    rst_n = 1'b1; ch_en = 4'hF; cyc = 0;
    write(2'd1, 4'd2, 1'b0);
    adv(1);  wr_en = 1'b0;
    chk("c1_tick", 32'(base_tick), 32'h0);
    adv(3);  chk("c3_tick", 32'(base_tick), 32'h0);
    adv(4);  chk("c4_tick", 32'(base_tick), 32'h1);
             chk("c4_d", 32'(d), 32'h0);
    adv(5);  chk("c5_tick", 32'(base_tick), 32'h0);
             chk("c5_d", 32'(d), 32'hD);
             chk("c5_d2", 32'(d2), 32'h7);
    adv(9);  chk("c9_d", 32'(d), 32'h0);
             chk("c9_d2", 32'(d2), 32'h0);
    adv(12); chk("c12_d", 32'(d), 32'h0);
    adv(13); chk("c13_d", 32'(d), 32'hF);
    adv(24); chk("c24_d", 32'(d), 32'hF);
    adv(25); chk("c25_d", 32'(d), 32'h0);

    // ch2 div=1 PULSE.
    write(2'd2, 4'd1, 1'b1);
    adv(26); wr_en = 1'b0;
    chk("c26_d", 32'(d), 32'h0);
    adv(29); chk("c29_d2", 32'(d2), 32'h7);
    adv(32); chk("c32_d2b", 32'(d[2]), 32'h0);
    adv(33); chk("c33_d2b", 32'(d[2]), 32'h1);
    adv(34); chk("c34_d2b", 32'(d[2]), 32'h0);
    adv(41); chk("c41_d2b", 32'(d[2]), 32'h1);
    adv(42); chk("c42_d2b", 32'(d[2]), 32'h0);
             chk("c42_d1b", 32'(d[1]), 32'h1);

    // Disable ch1 mid-period, then re-enable.
    ch_en = 4'hD;
    adv(43); chk("c43_d1b", 32'(d[1]), 32'h0);
    adv(50); chk("c50_d1b", 32'(d[1]), 32'h0);
    ch_en = 4'hF;
    adv(60); chk("c60_d1b", 32'(d[1]), 32'h0);
    adv(61); chk("c61_d1b", 32'(d[1]), 32'h1);

    // Sync at an arbitrary cycle.
    adv(62); sync = 1'b1;
    adv(63); sync = 1'b0;
    chk("c63_d", 32'(d), 32'h0);
    chk("c63_tick", 32'(base_tick), 32'h0);
    adv(66); chk("c66_tick", 32'(base_tick), 32'h0);
    adv(67); chk("c67_tick", 32'(base_tick), 32'h1);
    adv(68); chk("c68_d", 32'(d), 32'h9);
    adv(72); chk("c72_d", 32'(d), 32'h4);
    adv(76); chk("c76_d", 32'(d), 32'hB);

    // Sync on the base wrap cycle swallows the tick.
    adv(78); sync = 1'b1;
    adv(79); sync = 1'b0;
    chk("c79_tick", 32'(base_tick), 32'h0);
    chk("c79_d", 32'(d), 32'h0);
    adv(82); chk("c82_tick", 32'(base_tick), 32'h0);
    adv(83); chk("c83_tick", 32'(base_tick), 32'h1);

    // Write ch1 exactly when its event is due.
    adv(91); write(2'd1, 4'd1, 1'b0);
    adv(92); wr_en = 1'b0;
    chk("c92_d", 32'(d), 32'h9);
    adv(99);  chk("c99_d1b", 32'(d[1]), 32'h0);
    adv(100); chk("c100_d1b", 32'(d[1]), 32'h1);
    adv(102); chk("c102_d", 32'(d), 32'hB);

    // Asynchronous reset between edges.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_d", 32'(d), 32'h0);
    chk("arst_tick", 32'(base_tick), 32'h0);
    chk("arst_d2", 32'(d2), 32'h0);
    @(negedge clk);
    rst_n = 1'b1; cyc = 0;
    adv(3); chk("r3_tick", 32'(base_tick), 32'h0);
    adv(4); chk("r4_tick", 32'(base_tick), 32'h1);
    adv(5); chk("r5_d", 32'(d), 32'hF);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
